// File: rtl/program_counter_if.sv
// Fetch-side bundle for the program counter:
// load target, load/increment enables and the current PC.
interface program_counter_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in;
    logic             ld;
    logic             inc;
    logic [WIDTH-1:0] out;

    modport master (
        output in,
        output ld,
        output inc,
        input  out
    );

    modport slave (
        input  in,
        input  ld,
        input  inc,
        output out
    );
endinterface

// File: rtl/program_counter.sv
// Xiphos program counter: holds the current fetch address and
// either holds, increments or loads a branch/jump target each cycle.
module program_counter #(
    parameter int             WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input logic              clk,
    input logic              reset,
    program_counter_if.slave pc
);
    logic [WIDTH-1:0] pc_q;

    // Load outranks increment; increment wraps modulo 2^WIDTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_VALUE;
        end else if (pc.ld) begin
            pc_q <= pc.in;
        end else if (pc.inc) begin
            pc_q <= pc_q + WIDTH'(1);
        end
    end

    assign pc.out = pc_q;
endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed cases
// followed by randomized load/increment/reset traffic.
module tb_program_counter;
    localparam int WIDTH = 16;
    localparam int MODV  = 1 << WIDTH;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;
    int   model;

    program_counter_if #(.WIDTH(WIDTH)) pif ();

    program_counter #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(16'h0000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .pc   (pif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic l, input logic i,
                         input logic [WIDTH-1:0] v);
        pif.ld  = l;
        pif.inc = i;
        pif.in  = v;
    endtask

    // Reference: what the PC should hold after one rising edge.
    task automatic step(input string tag);
        @(posedge clk);
        if (reset) begin
            if (pif.ld)
                model = int'(pif.in);
            else if (pif.inc)
                model = (model + 1) % MODV;
        end else begin
            model = 0;
        end
        #1;
        check(tag, pif.out, WIDTH'(model));
    endtask

    task automatic reset_pulse(input string tag);
        #2;
        reset = 1'b0;
        #1;
        model = 0;
        check(tag, pif.out, WIDTH'(model));
        #1;
        reset = 1'b1;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        model  = 0;
        reset  = 1'b0;
        drive(1'b0, 1'b0, '0);
        #1;
        check("reset_now", pif.out, 16'h0000);
        for (int k = 0; k < 3; k++)
            step("reset_hold");
        reset = 1'b1;
        step("reset_release");

        drive(1'b0, 1'b1, 16'h5555);
        for (int k = 0; k < 5; k++)
            step("inc_run");
        drive(1'b0, 1'b0, 16'h5555);
        step("hold_a");
        step("hold_b");
        check("hold_abs", pif.out, 16'h0005);

        drive(1'b1, 1'b0, 16'h1234);
        step("load");
        check("load_abs", pif.out, 16'h1234);
        drive(1'b0, 1'b1, 16'h0000);
        step("load_inc");
        check("load_inc_abs", pif.out, 16'h1235);

        reset_pulse("reset_mid");
        step("post_reset_inc");
        check("post_reset_abs", pif.out, 16'h0001);

        drive(1'b1, 1'b1, 16'h00A0);
        step("ld_and_inc");
        check("ld_and_inc_abs", pif.out, 16'h00A0);

        drive(1'b1, 1'b0, 16'hFFFE);
        step("wrap_load");
        drive(1'b0, 1'b1, 16'h0000);
        step("wrap_ffff");
        check("wrap_ffff_abs", pif.out, 16'hFFFF);
        step("wrap_zero");
        check("wrap_zero_abs", pif.out, 16'h0000);
        step("wrap_one");
        check("wrap_one_abs", pif.out, 16'h0001);

        for (int k = 0; k < 400; k++) begin
            // A decoy value mid-cycle; only the final one is sampled.
            drive(1'($urandom), 1'($urandom), 16'($urandom));
            #1;
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 6,
                  ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom));
            if ($urandom_range(0, 19) == 0)
                reset_pulse("rand_reset");
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
